// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store,
// one outstanding transaction, round-robin arbitration, flush drop and timeout.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_valid_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_bmask_i,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_valid_o,
  input  logic                flush_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_bmask_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                if_stall_o,
  output logic                lsu_stall_o,
  output logic                timeout_o
);
  localparam int BM_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t              r_state, w_next;
  logic                r_owner, r_last_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata, r_if_rdata, r_lsu_rdata;
  logic [BM_W-1:0]     r_bmask;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_drop, r_timeout, r_if_valid, r_lsu_valid;
  logic                w_if_elig, w_lsu_elig, w_win, w_pick_lsu;
  logic                w_busy, w_done, w_tmo, w_end, w_drop, w_deliver;
  logic [DATA_W-1:0]   w_data;
  // owner encoding: 0 = fetch, 1 = load/store
  assign w_if_elig  = if_req_i & ~flush_i & ~r_if_valid;
  assign w_lsu_elig = lsu_req_i & ~r_lsu_valid;
  assign w_win      = w_if_elig | w_lsu_elig;
  assign w_pick_lsu = w_lsu_elig & (~w_if_elig | ~r_last_owner);
  assign w_busy     = r_state != IDLE;
  assign w_done     = (r_state == WAIT) & mem_rvalid_i;
  assign w_tmo      = w_busy & ~w_done & (r_cnt == CNT_W'(TIMEOUT_CYC - 2));
  assign w_end      = w_done | w_tmo;
  // a flush in the completing cycle already makes the fetch stale
  assign w_drop     = r_drop | (flush_i & ~r_owner);
  assign w_deliver  = w_end & (r_owner | ~w_drop);
  assign w_data     = w_done ? mem_rdata_i : '0;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_win ? REQ : IDLE;
    else if (w_end) w_next = IDLE;
    else if (r_state == REQ && mem_gnt_i) w_next = WAIT;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_bmask      <= '0;
      r_cnt        <= '0;
      r_drop       <= 1'b0;
      r_timeout    <= 1'b0;
      r_if_valid   <= 1'b0;
      r_lsu_valid  <= 1'b0;
      r_if_rdata   <= '0;
      r_lsu_rdata  <= '0;
    end else begin
      if (r_state == IDLE && w_win) begin
        r_owner <= w_pick_lsu;
        r_addr  <= w_pick_lsu ? lsu_addr_i : if_addr_i;
        r_we    <= w_pick_lsu & lsu_we_i;
        r_wdata <= w_pick_lsu ? lsu_wdata_i : '0;
        r_bmask <= w_pick_lsu ? lsu_bmask_i : '1;
        r_cnt   <= '0;
      end else if (w_busy) r_cnt <= r_cnt + 1'b1;
      r_drop      <= w_end ? 1'b0 : (r_drop | (w_busy & flush_i & ~r_owner));
      r_if_valid  <= w_deliver & ~r_owner;
      r_lsu_valid <= w_deliver & r_owner;
      if (w_deliver && !r_owner) r_if_rdata <= w_data;
      if (w_deliver && r_owner) r_lsu_rdata <= w_data;
      if (w_end) r_last_owner <= r_owner;
      if (w_tmo) r_timeout <= 1'b1;
    end
  end
  assign mem_req_o   = r_state == REQ;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_bmask_o = r_bmask;
  assign if_rdata_o  = r_if_rdata;
  assign if_valid_o  = r_if_valid;
  assign lsu_rdata_o = r_lsu_rdata;
  assign lsu_valid_o = r_lsu_valid;
  assign timeout_o   = r_timeout;
  assign if_stall_o  = if_req_i & ~r_if_valid & ~flush_i;
  assign lsu_stall_o = lsu_req_i & ~r_lsu_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-by-cycle checks of mem_port_arbiter.
module tb_mem_port_arbiter;
  logic        clk_i, rst_i;
  logic        if_req_i, lsu_req_i, lsu_we_i, flush_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_addr_i, lsu_addr_i, lsu_wdata_i, mem_rdata_i;
  logic [3:0]  lsu_bmask_i;
  logic [31:0] if_rdata_o, lsu_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_bmask_o;
  logic        if_valid_o, lsu_valid_o, mem_req_o, mem_we_o;
  logic        if_stall_o, lsu_stall_o, timeout_o;
  int          n_tests = 0;
  int          n_fail = 0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_bmask_i(lsu_bmask_i), .lsu_rdata_o(lsu_rdata_o), .lsu_valid_o(lsu_valid_o),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_bmask_o(mem_bmask_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .if_stall_o(if_stall_o), .lsu_stall_o(lsu_stall_o), .timeout_o(timeout_o)
  );
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic serve(input logic [31:0] d);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = d;
    tick();
    mem_rvalid_i = 1'b0;
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
  endtask
  initial begin
    rst_i = 1'b1;
    {if_req_i, lsu_req_i, lsu_we_i, flush_i, mem_gnt_i, mem_rvalid_i} = '0;
    {if_addr_i, lsu_addr_i, lsu_wdata_i, mem_rdata_i} = '0;
    lsu_bmask_i = '0;
    #12;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_valids", {if_valid_o, lsu_valid_o, timeout_o}, 0);
    check("rst_rdata", {if_rdata_o, lsu_rdata_o}, 0);
    check("rst_mem_bus", {mem_we_o, mem_addr_o, mem_bmask_o}, 0);
    tick();
    rst_i = 1'b0;
    tick();
    // fetch latency
    if_req_i = 1'b1;
    if_addr_i = 32'h100;
    #1 check("f_c0_stall", if_stall_o, 1);
    check("f_c0_req", mem_req_o, 0);
    tick();
    mem_gnt_i = 1'b1;
    #1 check("f_c1_req", mem_req_o, 1);
    check("f_c1_bus", {mem_we_o, mem_addr_o, mem_bmask_o}, {1'b0, 32'h100, 4'hF});
    check("f_c1_stall", if_stall_o, 1);
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h13;
    #1 check("f_c2_req", mem_req_o, 0);
    check("f_c2_stall", if_stall_o, 1);
    tick();
    mem_rvalid_i = 1'b0;
    #1 check("f_c3_valid", if_valid_o, 1);
    check("f_c3_rdata", if_rdata_o, 32'h13);
    check("f_c3_stall", if_stall_o, 0);
    tick();
    if_req_i = 1'b0;
    #1 check("f_c4_valid", if_valid_o, 0);
    check("f_c4_no_rearb", mem_req_o, 0);
    check("f_c4_hold", if_rdata_o, 32'h13);
    // round-robin
    do_reset();
    if_req_i = 1'b1;
    if_addr_i = 32'h200;
    lsu_req_i = 1'b1;
    lsu_we_i = 1'b0;
    lsu_addr_i = 32'h40;
    #1 check("rr_stalls", {if_stall_o, lsu_stall_o}, 2'b11);
    tick();
    #1 check("rr_first_lsu", {mem_req_o, mem_addr_o}, {1'b1, 32'h40});
    serve(32'hAAAA0001);
    #1 check("rr_lsu_valid", {lsu_valid_o, if_valid_o}, 2'b10);
    check("rr_lsu_rdata", lsu_rdata_o, 32'hAAAA0001);
    check("rr_stalls2", {if_stall_o, lsu_stall_o}, 2'b10);
    tick();
    #1 check("rr_if_next", {mem_req_o, mem_addr_o, mem_bmask_o}, {1'b1, 32'h200, 4'hF});
    serve(32'h11);
    #1 check("rr_if_valid", {if_valid_o, lsu_valid_o}, 2'b10);
    check("rr_if_rdata", if_rdata_o, 32'h11);
    tick();
    #1 check("rr_lsu_again", {mem_req_o, mem_addr_o}, {1'b1, 32'h40});
    serve(32'h22);
    #1 check("rr_lsu_valid2", lsu_valid_o, 1);
    check("rr_lsu_rdata2", lsu_rdata_o, 32'h22);
    lsu_req_i = 1'b0;
    if_req_i = 1'b0;
    tick();
    #1 check("rr_idle", mem_req_o, 0);
    // store with delayed grant
    lsu_req_i = 1'b1;
    lsu_we_i = 1'b1;
    lsu_addr_i = 32'h2000;
    lsu_wdata_i = 32'hDEADBEEF;
    lsu_bmask_i = 4'b0011;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = (i == 3);
      #1 check("st_hold", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_bmask_o},
                 {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011});
      tick();
    end
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h12345678;
    #1 check("st_wait", {mem_req_o, lsu_stall_o, lsu_valid_o}, 3'b010);
    tick();
    mem_rvalid_i = 1'b0;
    #1 check("st_valid", {lsu_valid_o, lsu_stall_o}, 2'b10);
    check("st_rdata", lsu_rdata_o, 32'h12345678);
    lsu_req_i = 1'b0;
    lsu_we_i = 1'b0;
    tick();
    #1 check("st_pulse_end", lsu_valid_o, 0);
    // flush during WAIT
    if_req_i = 1'b1;
    if_addr_i = 32'h300;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    flush_i = 1'b1;
    if_req_i = 1'b0;
    #1 check("fl_stall", if_stall_o, 0);
    tick();
    flush_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hBAD;
    tick();
    mem_rvalid_i = 1'b0;
    #1 check("fl_no_valid", if_valid_o, 0);
    check("fl_rdata_kept", if_rdata_o, 32'h11);
    if_req_i = 1'b1;
    if_addr_i = 32'h304;
    tick();
    #1 check("fl_refetch", {mem_req_o, mem_addr_o}, {1'b1, 32'h304});
    serve(32'h55);
    #1 check("fl_refetch_valid", {if_valid_o, if_rdata_o}, {1'b1, 32'h55});
    if_req_i = 1'b0;
    tick();
    // timeout
    lsu_req_i = 1'b1;
    lsu_addr_i = 32'h80;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int c = 2; c < 8; c++) begin
      #1 check("to_wait", {lsu_valid_o, timeout_o}, 2'b00);
      tick();
    end
    #1 check("to_valid", {lsu_valid_o, timeout_o, mem_req_o}, 3'b110);
    check("to_rdata", lsu_rdata_o, 0);
    lsu_req_i = 1'b0;
    tick();
    tick();
    #1 check("to_sticky", {timeout_o, lsu_valid_o}, 2'b10);
    // reset during WAIT
    if_req_i = 1'b1;
    if_addr_i = 32'h400;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    #2 rst_i = 1'b1;
    if_req_i = 1'b0;
    #1 check("ar_outs", {mem_req_o, if_valid_o, lsu_valid_o, timeout_o}, 0);
    check("ar_bus", {mem_addr_o, if_rdata_o, lsu_rdata_o}, 0);
    tick();
    rst_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hFFFF;
    tick();
    mem_rvalid_i = 1'b0;
    #1 check("ar_stray", {if_valid_o, lsu_valid_o, mem_req_o, if_rdata_o}, 0);
    tick();
    #1 check("ar_idle", {mem_req_o, if_valid_o}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
